decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NREGS, default 32, register-file depth (x0..x31).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- instrD  in  32  instruction from fetch stage.
- PCD  in  32  PC of instrD.
- stallE  in  1  hold Execute register.
- flushE  in  1  load bubble into Execute register.
- regWriteW  in  1  writeback enable.
- rdW  in  5  writeback register.
- resultW  in  32  writeback data.
- rs1D, rs2D  out  5  source indices to hazard unit, combinational.
- RD1E, RD2E, immE, PCE  out  32  registered operands, immediate and PC.
- rdE, rs1E, rs2E  out  5  registered register indices.
- regWriteE, memWriteE, ALUSrcE, branchE, jumpE, illegalE  out  1  registered controls.
- resultSrcE  out  2  registered control.
- ALUControlE  out  3  registered control.

Function
REQ-005 SHALL decode opcodes R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111.
REQ-006 SHALL sign-extend immediates: I for I-ALU/load, S for store, B for branch, J for jal; R-type gives immE=0.
REQ-007 SHALL map ALU ops: add/addi/load/store=ADD 000; sub/branch=SUB 001; and=010; or=011; slt=101.
REQ-008 SHALL map resultSrc: 00 ALU, 01 memory (load), 10 PC+4 (jal).
REQ-009 SHALL treat any other opcode as illegal: all controls 0, illegalE=1.
REQ-010 SHALL read rs1=instrD[19:15] and rs2=instrD[24:20] combinationally; x0 always reads 0.
REQ-011 SHALL write resultW to rdW on the rising edge when regWriteW=1 and rdW!=0; writes to x0 are ignored.
REQ-012 SHALL let register-file writes proceed regardless of stallE or flushE.
REQ-013 SHALL update the Execute register every rising edge with 1-cycle D-to-E latency.
REQ-014 SHALL give Execute-register update priority: reset > flushE > stallE > load.
REQ-015 SHALL, on flushE=1, clear all E outputs to 0, including illegalE, regardless of stallE.
REQ-016 SHALL, on stallE=1 with flushE=0, hold all E outputs unchanged.

Reset
REQ-017 SHALL, while rst=0, immediately force all E outputs and all registers x1..x31 to 0.
REQ-018 SHALL ignore regWriteW while rst=0.
REQ-019 SHALL start normal operation on the first rising edge after rst returns to 1.

Configuration
REQ-020 SHALL support macro RF_BYPASS_EN. When defined, a same-cycle write (regWriteW=1, rdW=rs, rdW!=0) forwards resultW to the read port. When undefined, the read returns the pre-write value.

Structure
REQ-021 SHALL take opcode constants, ALUControl encodings and resultSrc encodings from shared package riscv_pkg.
REQ-022 SHALL implement the register file as sub-module regfile: two async read ports, one sync write port, async active-low clear.
REQ-023 SHALL keep immediate generation and control decode combinational inside decode.

Verification
REQ-024 SHALL cover: instrD=0x00500093 (addi x1,x0,5) -> next cycle regWriteE=1, ALUSrcE=1, immE=5, rdE=1, RD1E=0, ALUControlE=000.
REQ-025 SHALL cover: write x1=0xDEADBEEF and x2=1 via W port, then instrD=0x002081B3 (add x3,x1,x2) -> RD1E=0xDEADBEEF, RD2E=1, rdE=3, ALUSrcE=0.
REQ-026 SHALL cover: instrD=0xFE000CE3 (beq x0,x0,-8) -> branchE=1, immE=0xFFFFFFF8, ALUControlE=001, regWriteE=0.
REQ-027 SHALL cover: same-cycle write x1=0x55 and read of x1 -> RD1E=0x55 with RF_BYPASS_EN, previous x1 value without it.
REQ-028 SHALL cover: flushE=1 with stallE=1 -> all E controls 0; stallE=1 alone for 3 cycles -> E outputs unchanged.
REQ-029 SHALL cover: rst=0 mid-stream -> E outputs 0 without waiting for a clock edge; write to x0 then read x0 -> 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants: opcodes, ALU and result-select encodings.
// Control bundle carried from Decode into the Execute register.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_sel_e;

  typedef struct packed {
    logic     regWrite;
    logic     memWrite;
    logic     aluSrc;
    logic     branch;
    logic     jump;
    logic     illegal;
    res_src_e resultSrc;
    alu_op_e  aluCtl;
  } ctrl_t;

  // f7b5 only distinguishes sub from add on R-type
  function automatic alu_op_e alu_dec(
    input logic [2:0] f3,
    input logic       f7b5
  );
    alu_op_e op;
    case (f3)
      3'b000:  op = f7b5 ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      3'b010:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file: two async read ports, one sync write port, async clear.
// Define RF_BYPASS_EN to forward a same-cycle write to the read ports.
import riscv_pkg::*;

module regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1_i,
  input  logic [4:0]      ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] rf_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (we_i && wa_i != 5'd0) begin
      rf_q[wa_i] <= wd_i;
    end
  end

  function automatic logic [XLEN-1:0] rd(
    input logic [4:0] ra
  );
    logic [XLEN-1:0] v;
    if (ra == 5'd0) begin
      v = '0;
`ifdef RF_BYPASS_EN
    end else if (we_i && wa_i == ra) begin
      v = wd_i;
`endif
    end else begin
      v = rf_q[ra];
    end
    return v;
  endfunction

  assign rd1_o = rd(ra1_i);
  assign rd2_o = rd(ra2_i);

endmodule

// File: rtl/decode.sv
// Decode stage: control decode, immediate gen, regfile read, ID/EX register.
// RF_BYPASS_EN (optional) enables same-cycle write-to-read forwarding.
import riscv_pkg::*;

module decode #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instrD,
  input  logic [XLEN-1:0] PCD,
  input  logic            stallE,
  input  logic            flushE,
  input  logic            regWriteW,
  input  logic [4:0]      rdW,
  input  logic [XLEN-1:0] resultW,
  output logic [4:0]      rs1D,
  output logic [4:0]      rs2D,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] immE,
  output logic [XLEN-1:0] PCE,
  output logic [4:0]      rdE,
  output logic [4:0]      rs1E,
  output logic [4:0]      rs2E,
  output logic            regWriteE,
  output logic            memWriteE,
  output logic            ALUSrcE,
  output logic            branchE,
  output logic            jumpE,
  output logic            illegalE,
  output logic [1:0]      resultSrcE,
  output logic [2:0]      ALUControlE
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            f7b5;
  ctrl_t           ctrl_d;
  ctrl_t           ctrl_q;
  imm_sel_e        imm_sel;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;
  logic [XLEN-1:0] rd1_q;
  logic [XLEN-1:0] rd2_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] pc_q;
  logic [4:0]      rd_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;

  assign opcode = instrD[6:0];
  assign funct3 = instrD[14:12];
  assign f7b5   = instrD[30];
  assign rs1D   = instrD[19:15];
  assign rs2D   = instrD[24:20];

  always_comb begin
    ctrl_d  = '0;
    imm_sel = IMM_NONE;
    unique case (1'b1)
      (opcode == OP_R): begin
        ctrl_d.regWrite = 1'b1;
        ctrl_d.aluCtl   = alu_dec(funct3, f7b5);
      end
      (opcode == OP_I): begin
        ctrl_d.regWrite = 1'b1;
        ctrl_d.aluSrc   = 1'b1;
        ctrl_d.aluCtl   = alu_dec(funct3, 1'b0);
        imm_sel         = IMM_I;
      end
      (opcode == OP_LOAD): begin
        ctrl_d.regWrite  = 1'b1;
        ctrl_d.aluSrc    = 1'b1;
        ctrl_d.resultSrc = RES_MEM;
        imm_sel          = IMM_I;
      end
      (opcode == OP_STORE): begin
        ctrl_d.memWrite = 1'b1;
        ctrl_d.aluSrc   = 1'b1;
        imm_sel         = IMM_S;
      end
      (opcode == OP_BRANCH): begin
        ctrl_d.branch = 1'b1;
        ctrl_d.aluCtl = ALU_SUB;
        imm_sel       = IMM_B;
      end
      (opcode == OP_JAL): begin
        ctrl_d.regWrite  = 1'b1;
        ctrl_d.jump      = 1'b1;
        ctrl_d.resultSrc = RES_PC4;
        imm_sel          = IMM_J;
      end
      default: begin
        ctrl_d.illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    imm_d = '0;
    unique case (imm_sel)
      IMM_I: imm_d = {{(XLEN-12){instrD[31]}},
                      instrD[31:20]};
      IMM_S: imm_d = {{(XLEN-12){instrD[31]}},
                      instrD[31:25], instrD[11:7]};
      IMM_B: imm_d = {{(XLEN-12){instrD[31]}},
                      instrD[7], instrD[30:25],
                      instrD[11:8], 1'b0};
      IMM_J: imm_d = {{(XLEN-20){instrD[31]}},
                      instrD[19:12], instrD[20],
                      instrD[30:21], 1'b0};
      default: imm_d = '0;
    endcase
  end

  regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst),
    .ra1_i (rs1D),
    .ra2_i (rs2D),
    .rd1_o (rd1_d),
    .rd2_o (rd2_d),
    .we_i  (regWriteW),
    .wa_i  (rdW),
    .wd_i  (resultW)
  );

  // flush wins over stall so a bubble can be injected while held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else if (flushE) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else if (!stallE) begin
      ctrl_q <= ctrl_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      pc_q   <= PCD;
      rd_q   <= instrD[11:7];
      rs1_q  <= rs1D;
      rs2_q  <= rs2D;
    end
  end

  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign immE        = imm_q;
  assign PCE         = pc_q;
  assign rdE         = rd_q;
  assign rs1E        = rs1_q;
  assign rs2E        = rs2_q;
  assign regWriteE   = ctrl_q.regWrite;
  assign memWriteE   = ctrl_q.memWrite;
  assign ALUSrcE     = ctrl_q.aluSrc;
  assign branchE     = ctrl_q.branch;
  assign jumpE       = ctrl_q.jump;
  assign illegalE    = ctrl_q.illegal;
  assign resultSrcE  = ctrl_q.resultSrc;
  assign ALUControlE = ctrl_q.aluCtl;

endmodule

// File: tb/tb_decode.sv
// Directed table-driven bench for the decode stage.
// Covers decode, immediates, stall/flush, async reset and x0 handling.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instrD = '0;
  logic [31:0] PCD = '0;
  logic        stallE = 1'b0;
  logic        flushE = 1'b0;
  logic        regWriteW = 1'b0;
  logic [4:0]  rdW = '0;
  logic [31:0] resultW = '0;
  logic [4:0]  rs1D, rs2D;
  logic [31:0] RD1E, RD2E, immE, PCE;
  logic [4:0]  rdE, rs1E, rs2E;
  logic        regWriteE, memWriteE, ALUSrcE;
  logic        branchE, jumpE, illegalE;
  logic [1:0]  resultSrcE;
  logic [2:0]  ALUControlE;

  decode dut (
    .clk         (clk),
    .rst         (rst),
    .instrD      (instrD),
    .PCD         (PCD),
    .stallE      (stallE),
    .flushE      (flushE),
    .regWriteW   (regWriteW),
    .rdW         (rdW),
    .resultW     (resultW),
    .rs1D        (rs1D),
    .rs2D        (rs2D),
    .RD1E        (RD1E),
    .RD2E        (RD2E),
    .immE        (immE),
    .PCE         (PCE),
    .rdE         (rdE),
    .rs1E        (rs1E),
    .rs2E        (rs2E),
    .regWriteE   (regWriteE),
    .memWriteE   (memWriteE),
    .ALUSrcE     (ALUSrcE),
    .branchE     (branchE),
    .jumpE       (jumpE),
    .illegalE    (illegalE),
    .resultSrcE  (resultSrcE),
    .ALUControlE (ALUControlE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rw;
    logic        mw;
    logic        as;
    logic        br;
    logic        jp;
    logic        il;
    logic [1:0]  rsrc;
    logic [2:0]  alu;
  } eout_t;

  typedef struct packed {
    logic [31:0] instr;
    eout_t       e;
  } vec_t;

  int pass_cnt = 0;
  int total = 0;
  vec_t vecs [12];

  function automatic eout_t mk(
    input logic [31:0] rd1,
    input logic [31:0] rd2,
    input logic [31:0] imm,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [5:0]  c,
    input logic [1:0]  rsrc,
    input logic [2:0]  alu
  );
    eout_t e;
    e.rd1  = rd1;
    e.rd2  = rd2;
    e.imm  = imm;
    e.pc   = '0;
    e.rd   = rd;
    e.rs1  = rs1;
    e.rs2  = rs2;
    {e.rw, e.mw, e.as, e.br, e.jp, e.il} = c;
    e.rsrc = rsrc;
    e.alu  = alu;
    return e;
  endfunction

  function automatic eout_t cur();
    eout_t e;
    e.rd1  = RD1E;
    e.rd2  = RD2E;
    e.imm  = immE;
    e.pc   = PCE;
    e.rd   = rdE;
    e.rs1  = rs1E;
    e.rs2  = rs2E;
    e.rw   = regWriteE;
    e.mw   = memWriteE;
    e.as   = ALUSrcE;
    e.br   = branchE;
    e.jp   = jumpE;
    e.il   = illegalE;
    e.rsrc = resultSrcE;
    e.alu  = ALUControlE;
    return e;
  endfunction

  task automatic chk32(
    input string       n,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", n, got, exp);
  endtask

  task automatic chk_e(
    input string n,
    input eout_t got,
    input eout_t exp
  );
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", n, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end

  initial begin
    eout_t exp;
    eout_t expA;
    logic [31:0] byp_exp;

    // x1=DEADBEEF, x2=1, all others 0 when the table runs
    vecs[0]  = '{32'h00500093, mk(32'h0, 32'h0, 32'h5,
                 5'd1, 5'd0, 5'd5, 6'b101000, 2'b00, 3'b000)};
    vecs[1]  = '{32'h002081B3, mk(32'hDEADBEEF, 32'h1, 32'h0,
                 5'd3, 5'd1, 5'd2, 6'b100000, 2'b00, 3'b000)};
    vecs[2]  = '{32'hFE000CE3, mk(32'h0, 32'h0, 32'hFFFFFFF8,
                 5'd25, 5'd0, 5'd0, 6'b000100, 2'b00, 3'b001)};
    vecs[3]  = '{32'h40208233, mk(32'hDEADBEEF, 32'h1, 32'h0,
                 5'd4, 5'd1, 5'd2, 6'b100000, 2'b00, 3'b001)};
    vecs[4]  = '{32'h0020F2B3, mk(32'hDEADBEEF, 32'h1, 32'h0,
                 5'd5, 5'd1, 5'd2, 6'b100000, 2'b00, 3'b010)};
    vecs[5]  = '{32'h0020E333, mk(32'hDEADBEEF, 32'h1, 32'h0,
                 5'd6, 5'd1, 5'd2, 6'b100000, 2'b00, 3'b011)};
    vecs[6]  = '{32'h0020A3B3, mk(32'hDEADBEEF, 32'h1, 32'h0,
                 5'd7, 5'd1, 5'd2, 6'b100000, 2'b00, 3'b101)};
    vecs[7]  = '{32'hFFC0A403, mk(32'hDEADBEEF, 32'h0, 32'hFFFFFFFC,
                 5'd8, 5'd1, 5'd28, 6'b101000, 2'b01, 3'b000)};
    vecs[8]  = '{32'h0020A423, mk(32'hDEADBEEF, 32'h1, 32'h8,
                 5'd8, 5'd1, 5'd2, 6'b011000, 2'b00, 3'b000)};
    vecs[9]  = '{32'h010000EF, mk(32'h0, 32'h0, 32'h10,
                 5'd1, 5'd0, 5'd16, 6'b100010, 2'b10, 3'b000)};
    vecs[10] = '{32'hFFFFFFFF, mk(32'h0, 32'h0, 32'h0,
                 5'd31, 5'd31, 5'd31, 6'b000001, 2'b00, 3'b000)};
    vecs[11] = '{32'hFFF10493, mk(32'h1, 32'h0, 32'hFFFFFFFF,
                 5'd9, 5'd2, 5'd31, 6'b101000, 2'b00, 3'b000)};

    #1 rst = 1'b0;
    #1 chk_e("reset_state", cur(), '0);
    cyc();
    cyc();
    rst = 1'b1;

    instrD    = 32'h00000013;
    regWriteW = 1'b1;
    rdW       = 5'd1;
    resultW   = 32'hDEADBEEF;
    cyc();
    rdW       = 5'd2;
    resultW   = 32'h1;
    cyc();
    regWriteW = 1'b0;

    for (int i = 0; i < 12; i++) begin
      instrD = vecs[i].instr;
      PCD    = 32'h100 + 32'(i * 4);
      #1;
      chk32($sformatf("rs1D_%0d", i), {27'd0, rs1D},
            {27'd0, vecs[i].e.rs1});
      chk32($sformatf("rs2D_%0d", i), {27'd0, rs2D},
            {27'd0, vecs[i].e.rs2});
      cyc();
      exp    = vecs[i].e;
      exp.pc = 32'h100 + 32'(i * 4);
      chk_e($sformatf("vec_%0d", i), cur(), exp);
    end

`ifdef RF_BYPASS_EN
    byp_exp = 32'h55;
`else
    byp_exp = 32'hDEADBEEF;
`endif
    instrD    = 32'h002081B3;
    PCD       = 32'h200;
    regWriteW = 1'b1;
    rdW       = 5'd1;
    resultW   = 32'h55;
    cyc();
    chk32("same_cycle_rd1", RD1E, byp_exp);
    regWriteW = 1'b0;
    cyc();
    chk32("after_write_rd1", RD1E, 32'h55);

    instrD    = 32'h000001B3;
    regWriteW = 1'b1;
    rdW       = 5'd0;
    resultW   = 32'h123;
    cyc();
    chk32("x0_write_rd1", RD1E, 32'h0);
    chk32("x0_write_rd2", RD2E, 32'h0);
    regWriteW = 1'b0;
    cyc();
    chk32("x0_after_rd1", RD1E, 32'h0);

    instrD = 32'h00500093;
    PCD    = 32'h300;
    expA   = mk(32'h0, 32'h0, 32'h5, 5'd1, 5'd0, 5'd5,
                6'b101000, 2'b00, 3'b000);
    expA.pc = 32'h300;
    cyc();
    chk_e("pre_stall", cur(), expA);
    stallE = 1'b1;
    instrD = 32'h0020F2B3;
    PCD    = 32'h304;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk_e($sformatf("stall_%0d", k), cur(), expA);
    end

    stallE = 1'b0;
    instrD = 32'hFFFFFFFF;
    cyc();
    chk32("illegal_set", {31'd0, illegalE}, 32'd1);
    stallE = 1'b1;
    flushE = 1'b1;
    cyc();
    chk_e("flush_over_stall", cur(), '0);
    stallE = 1'b0;
    flushE = 1'b0;

    instrD = 32'h002081B3;
    PCD    = 32'h400;
    cyc();
    chk32("pre_reset_rd1", RD1E, 32'h55);
    #2 rst = 1'b0;
    #1 chk_e("async_reset", cur(), '0);
    regWriteW = 1'b1;
    rdW       = 5'd2;
    resultW   = 32'h77;
    cyc();
    chk_e("held_in_reset", cur(), '0);
    regWriteW = 1'b0;
    rst       = 1'b1;
    cyc();
    chk32("rf_cleared_rd1", RD1E, 32'h0);
    chk32("rf_wr_ignored_rd2", RD2E, 32'h0);
    chk32("post_reset_rdE", {27'd0, rdE}, 32'd3);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
